// File: rtl/mc_core_param.sv
// mc_core_param: parametrised multicycle MIPS-subset core.
// FSM control, register file, ALU and IR/MDR/A/B/ALUOut holding registers,
// with a req/ready memory handshake that tolerates any number of wait states.
// Optional feature macro: EXC_EN (overflow / illegal-instruction exceptions,
// EPC and cause). Without it, epc/cause read 0 and illegal instructions are no-ops.
module mc_core_param #(
    parameter int          NREGS      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [3:0]  state,
    output logic        reg_write,
    output logic [31:0] epc,
    output logic [1:0]  cause
);
    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB     = 4'd5,
        S_EXC    = 4'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_SLT    = 6'h2A;

    state_t        state_q;
    logic [31:0]   pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0]   regs_q [NREGS];

    logic [5:0]    op, funct;
    logic [15:0]   imm;
    logic [31:0]   simm;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
    logic [31:0]   wr_data, sum_ab, diff_ab, sum_ai, alu_res;
    logic          rf_we, op_legal;

    // Instruction fields; register indices keep only the bits NREGS needs
    assign op     = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign rs_idx = ir_q[21 +: RW];
    assign rt_idx = ir_q[16 +: RW];
    assign rd_idx = ir_q[11 +: RW];

    assign sum_ab  = a_q + b_q;
    assign diff_ab = a_q - b_q;
    assign sum_ai  = a_q + simm;

    // Which opcode/funct combinations the core implements
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_RTYPE: op_legal = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                                 (funct == F_OR)  || (funct == F_SLT);
            OP_J, OP_BEQ, OP_ADDI, OP_LUI, OP_LW, OP_SW: op_legal = 1'b1;
            default:  op_legal = 1'b0;
        endcase
    end

    // ALU result used in EXEC; loads/stores/addi share the A+sext(imm) adder
    always_comb begin
        alu_res = sum_ai;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SUB:   alu_res = diff_ab;
                F_AND:   alu_res = a_q & b_q;
                F_OR:    alu_res = a_q | b_q;
                F_SLT:   alu_res = {31'b0, ($signed(a_q) < $signed(b_q))};
                default: alu_res = sum_ab;
            endcase
        end else if (op == OP_LUI) begin
            alu_res = {imm, 16'h0000};
        end
    end

`ifdef EXC_EN
    logic [31:0] epc_q;
    logic [1:0]  cause_q, exc_code_q;
    logic        alu_ovf;

    // Signed overflow: operands of equal effective sign producing a result of the other sign
    always_comb begin
        alu_ovf = 1'b0;
        if (op == OP_RTYPE && funct == F_ADD)
            alu_ovf = (a_q[31] == b_q[31]) && (sum_ab[31] != a_q[31]);
        else if (op == OP_RTYPE && funct == F_SUB)
            alu_ovf = (a_q[31] != b_q[31]) && (diff_ab[31] != a_q[31]);
        else if (op == OP_ADDI)
            alu_ovf = (a_q[31] == simm[31]) && (sum_ai[31] != a_q[31]);
    end

    assign epc   = epc_q;
    assign cause = cause_q;
`else
    assign epc   = 32'h0;
    assign cause = 2'd0;
`endif

    // Write-back port: R-type targets rd, everything else rt; loads return MDR
    assign rf_we   = (state_q == S_WB);
    assign wr_idx  = (op == OP_RTYPE) ? rd_idx : rt_idx;
    assign wr_data = (op == OP_LW) ? mdr_q : aluout_q;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
        // One register per slot; slot 0 is cleared on reset and never written
        always_ff @(posedge clock) begin
            if (reset)
                regs_q[gi] <= '0;
            else if (rf_we && (wr_idx == RW'(gi)) && (gi != 0))
                regs_q[gi] <= wr_data;
        end
    end

    // Memory side: instruction fetch uses PC, data accesses use ALUOut; reset gates the request
    assign mem_req   = !reset && ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : aluout_q;
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign reg_write = rf_we;

    // Control FSM and datapath holding registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
`ifdef EXC_EN
            epc_q      <= '0;
            cause_q    <= '0;
            exc_code_q <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + 32'd4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q      <= regs_q[rs_idx];
                    b_q      <= regs_q[rt_idx];
                    aluout_q <= pc_q + (simm << 2);
                    if (op_legal) begin
                        state_q <= S_EXEC;
                    end else begin
`ifdef EXC_EN
                        exc_code_q <= 2'd2;
                        state_q    <= S_EXC;
`else
                        state_q    <= S_FETCH;
`endif
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_BEQ: begin
                            if (a_q == b_q) pc_q <= aluout_q;
                            state_q <= S_FETCH;
                        end
                        OP_J: begin
                            pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            state_q <= S_FETCH;
                        end
                        OP_LW: begin
                            aluout_q <= alu_res;
                            state_q  <= S_MEMRD;
                        end
                        OP_SW: begin
                            aluout_q <= alu_res;
                            state_q  <= S_MEMWR;
                        end
                        default: begin
                            aluout_q <= alu_res;
                            state_q  <= S_WB;
`ifdef EXC_EN
                            if (alu_ovf) begin
                                exc_code_q <= 2'd1;
                                state_q    <= S_EXC;
                            end
`endif
                        end
                    endcase
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        state_q <= S_WB;
                    end
                end
                S_MEMWR: begin
                    if (mem_ready) state_q <= S_FETCH;
                end
                S_WB: state_q <= S_FETCH;
`ifdef EXC_EN
                S_EXC: begin
                    epc_q   <= pc_q - 32'd4;
                    cause_q <= exc_code_q;
                    pc_q    <= EXC_VECTOR;
                    state_q <= S_FETCH;
                end
`endif
                default: state_q <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_core_param.sv
// tb_mc_core_param: self-checking bench for mc_core_param.
// Two instances (NREGS=32 and NREGS=8) share one memory model; the unused one is held in reset.
// Store traffic is checked through a scoreboard: expected {addr,data} pairs are queued with the
// program, observed stores are queued by the memory model, and each test pops and compares them.
module tb_mc_core_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sel8  = 1'b0;
    always #5 clock = ~clock;

    logic rst_main, rst_small;
    assign rst_main  = reset | sel8;
    assign rst_small = reset | ~sel8;

    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic        m_req, m_we, m_rw, s_req, s_we, s_rw;
    logic [31:0] m_addr, m_wdata, m_pc, m_epc, s_addr, s_wdata, s_pc, s_epc;
    logic [3:0]  m_state, s_state;
    logic [1:0]  m_cause, s_cause;

    mc_core_param #(.NREGS(32), .RESET_PC(32'h0), .EXC_VECTOR(32'h80)) dut (
        .clock(clock), .reset(rst_main), .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(m_pc),
        .state(m_state), .reg_write(m_rw), .epc(m_epc), .cause(m_cause)
    );

    mc_core_param #(.NREGS(8), .RESET_PC(32'h0), .EXC_VECTOR(32'h80)) dut8 (
        .clock(clock), .reset(rst_small), .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(s_pc),
        .state(s_state), .reg_write(s_rw), .epc(s_epc), .cause(s_cause)
    );

    logic        req, we, rw;
    logic [31:0] addr, wdata, pc;
    logic [3:0]  st;
    assign req   = sel8 ? s_req   : m_req;
    assign we    = sel8 ? s_we    : m_we;
    assign rw    = sel8 ? s_rw    : m_rw;
    assign addr  = sel8 ? s_addr  : m_addr;
    assign wdata = sel8 ? s_wdata : m_wdata;
    assign pc    = sel8 ? s_pc    : m_pc;
    assign st    = sel8 ? s_state : m_state;

    localparam logic [31:0] LOOP = {6'h04, 5'd0, 5'd0, 16'hFFFF};  // beq $0,$0,-1

    logic [31:0] mem [1024];
    int          data_wait = 0;
    int          wcnt = 0;
    int          rw_count = 0;
    logic [63:0] obs_q [$];
    logic [63:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;

    // Memory model: decides ready for the coming edge; fetches never wait, data accesses wait data_wait cycles
    always @(negedge clock) begin
        if (rw) rw_count++;
        if (req) begin
            if (st == 4'd0 || wcnt >= data_wait) begin
                mem_ready = 1'b1;
                mem_rdata = mem[addr[11:2]];
                if (we) begin
                    mem[addr[11:2]] = wdata;
                    obs_q.push_back({addr, wdata});
                end
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = LOOP;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_stores(input int budget);
        for (int c = 0; c < budget && obs_q.size() < exp_q.size(); c++) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] snap;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        reset = 1'b1;
        @(posedge clock); #1;
        tests++; if (req !== 1'b0) begin fails++; $display("FAIL rst_req_low: got %b expected 0", req); end
        @(posedge clock); #1 reset = 1'b0; #1;
        tests++; if (addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h expected 00000000", addr); end
        tests++; if (req !== 1'b1) begin fails++; $display("FAIL rst_req_high: got %b expected 1", req); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h expected 00000000", pc); end
        tests++; if (st !== 4'd0) begin fails++; $display("FAIL rst_state: got %0d expected 0", st); end
        run(4);
        snap = pc;
        tests++; if (snap !== 32'h4) begin fails++; $display("FAIL rst_pre_pc: got %h expected 00000004", snap); end
        reset = 1'b1;
        @(posedge clock); #1;
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_mid_pc: got %h expected 00000000", pc); end
        tests++; if (st !== 4'd0) begin fails++; $display("FAIL rst_mid_state: got %0d expected 0", st); end
        reset = 1'b0;
        $display("[TB] reset: pc=%h state=%0d", pc, st);
    endtask

    task automatic test_alu();
        logic [63:0] e, o;
        int base;
        clear_mem();
        mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[2]  = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
        mem[3]  = enc_r(6'h22, 5'd4, 5'd1, 5'd2);
        mem[4]  = enc_r(6'h24, 5'd5, 5'd1, 5'd2);
        mem[5]  = enc_r(6'h25, 5'd6, 5'd1, 5'd2);
        mem[6]  = enc_r(6'h2A, 5'd7, 5'd1, 5'd2);
        mem[7]  = enc_r(6'h2A, 5'd8, 5'd2, 5'd4);
        mem[8]  = enc_r(6'h2A, 5'd9, 5'd4, 5'd1);
        for (int i = 0; i < 7; i++) mem[9 + i] = enc_i(6'h2B, 5'd0, 5'(3 + i), 16'(32'h100 + 4 * i));
        exp_q.push_back({32'h100, 32'd12});
        exp_q.push_back({32'h104, 32'hFFFF_FFFE});
        exp_q.push_back({32'h108, 32'd5});
        exp_q.push_back({32'h10C, 32'd7});
        exp_q.push_back({32'h110, 32'd1});
        exp_q.push_back({32'h114, 32'd0});
        exp_q.push_back({32'h118, 32'd1});
        do_reset();
        base = rw_count;
        run(12);
        tests++; if (pc !== 32'hC) begin fails++; $display("FAIL alu_pc12: got %h expected 0000000c", pc); end
        tests++; if (st !== 4'd0) begin fails++; $display("FAIL alu_state12: got %0d expected 0", st); end
        tests++; if (rw_count - base !== 3) begin fails++; $display("FAIL alu_regwrite_pulses: got %0d expected 3", rw_count - base); end
        wait_stores(400);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL alu_store: missing store, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("[TB] alu store addr=%h data=%h", o[63:32], o[31:0]);
                if (o !== e) begin fails++; $display("FAIL alu_store: got %h expected %h", o, e); end
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [63:0] e, o;
        clear_mem();
        mem[0]    = enc_j(26'h40);
        mem[12'h40] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
        mem[12'h41] = enc_i(6'h2B, 5'd0, 5'd3, 16'd16);
        mem[12'h42] = enc_i(6'h23, 5'd0, 5'd4, 16'd16);
        mem[12'h43] = enc_i(6'h2B, 5'd0, 5'd4, 16'd20);
        exp_q.push_back({32'd16, 32'd12});
        exp_q.push_back({32'd20, 32'd12});
        data_wait = 3;
        do_reset();
        run(11);
        tests++; if (we !== 1'b1 || req !== 1'b1) begin fails++; $display("FAIL mem_sw_req: got req=%b we=%b expected 1 1", req, we); end
        tests++; if (addr !== 32'd16) begin fails++; $display("FAIL mem_sw_addr: got %h expected 00000010", addr); end
        tests++; if (wdata !== 32'd12) begin fails++; $display("FAIL mem_sw_data: got %h expected 0000000c", wdata); end
        run(3);
        tests++; if (pc !== 32'h108 || st !== 4'd0) begin fails++; $display("FAIL mem_sw_done: got pc=%h st=%0d expected 00000108 0", pc, st); end
        run(4);
        tests++; if (st !== 4'd3 || we !== 1'b0 || addr !== 32'd16) begin fails++; $display("FAIL mem_lw_rd: got st=%0d we=%b addr=%h expected 3 0 00000010", st, we, addr); end
        run(3);
        tests++; if (st !== 4'd5 || rw !== 1'b1) begin fails++; $display("FAIL mem_lw_wb: got st=%0d rw=%b expected 5 1", st, rw); end
        run(1);
        tests++; if (pc !== 32'h10C || st !== 4'd0) begin fails++; $display("FAIL mem_lw_done: got pc=%h st=%0d expected 0000010c 0", pc, st); end
        wait_stores(400);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL mem_store: missing store, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("[TB] mem store addr=%h data=%h", o[63:32], o[31:0]);
                if (o !== e) begin fails++; $display("FAIL mem_store: got %h expected %h", o, e); end
            end
        end
        data_wait = 0;
    endtask

    task automatic test_branch();
        clear_mem();
        mem[0]    = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        mem[1]    = enc_j(26'h8);
        mem[8]    = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        mem[11]   = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        mem[12]   = enc_j(26'h100);
        do_reset();
        run(7);
        tests++; if (pc !== 32'h20 || st !== 4'd0) begin fails++; $display("FAIL br_j_pc: got pc=%h st=%0d expected 00000020 0", pc, st); end
        run(2);
        tests++; if (pc !== 32'h24 || st !== 4'd2) begin fails++; $display("FAIL br_exec: got pc=%h st=%0d expected 00000024 2", pc, st); end
        run(1);
        tests++; if (pc !== 32'h2C || st !== 4'd0) begin fails++; $display("FAIL br_taken: got pc=%h st=%0d expected 0000002c 0", pc, st); end
        run(3);
        tests++; if (pc !== 32'h30) begin fails++; $display("FAIL br_not_taken: got pc=%h expected 00000030", pc); end
        run(3);
        tests++; if (pc !== 32'h400 || st !== 4'd0) begin fails++; $display("FAIL br_jump_far: got pc=%h st=%0d expected 00000400 0", pc, st); end
        $display("[TB] branch: final pc=%h", pc);
    endtask

    task automatic test_exceptions();
        logic [63:0] e, o;
        clear_mem();
        mem[0]    = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF);
        mem[1]    = enc_i(6'h0F, 5'd0, 5'd6, 16'h8000);
        mem[2]    = enc_r(6'h22, 5'd1, 5'd5, 5'd6);
        mem[3]    = enc_j(26'h10);
        mem[16]   = enc_r(6'h20, 5'd2, 5'd1, 5'd1);
        mem[17]   = enc_i(6'h2B, 5'd0, 5'd2, 16'h200);
        mem[32]   = enc_i(6'h2B, 5'd0, 5'd2, 16'h200);
`ifdef EXC_EN
        exp_q.push_back({32'h200, 32'h0});
`else
        exp_q.push_back({32'h200, 32'hFFFF_FFFE});
`endif
        do_reset();
        run(15);
        tests++; if (pc !== 32'h40) begin fails++; $display("FAIL exc_setup_pc: got %h expected 00000040", pc); end
        run(3);
`ifdef EXC_EN
        tests++; if (st !== 4'd6) begin fails++; $display("FAIL exc_ovf_state: got %0d expected 6", st); end
        run(1);
        tests++; if (pc !== 32'h80 || m_epc !== 32'h40 || m_cause !== 2'd1) begin
            fails++; $display("FAIL exc_ovf: got pc=%h epc=%h cause=%0d expected 00000080 00000040 1", pc, m_epc, m_cause); end
`else
        tests++; if (st !== 4'd5) begin fails++; $display("FAIL exc_off_wb: got %0d expected 5", st); end
        run(1);
        tests++; if (pc !== 32'h44 || m_epc !== 32'h0 || m_cause !== 2'd0) begin
            fails++; $display("FAIL exc_off_add: got pc=%h epc=%h cause=%0d expected 00000044 00000000 0", pc, m_epc, m_cause); end
`endif
        wait_stores(200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL exc_store: missing store, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("[TB] exc store addr=%h data=%h", o[63:32], o[31:0]);
                if (o !== e) begin fails++; $display("FAIL exc_store: got %h expected %h", o, e); end
            end
        end
        clear_mem();
        mem[0] = 32'hFC00_0000;
        do_reset();
`ifdef EXC_EN
        run(3);
        tests++; if (pc !== 32'h80 || m_epc !== 32'h0 || m_cause !== 2'd2) begin
            fails++; $display("FAIL exc_illegal: got pc=%h epc=%h cause=%0d expected 00000080 00000000 2", pc, m_epc, m_cause); end
`else
        run(2);
        tests++; if (pc !== 32'h4 || st !== 4'd0 || m_cause !== 2'd0) begin
            fails++; $display("FAIL exc_illegal_nop: got pc=%h st=%0d cause=%0d expected 00000004 0 0", pc, st, m_cause); end
`endif
        $display("[TB] illegal: pc=%h cause=%0d", pc, m_cause);
    endtask

    task automatic test_nregs8();
        logic [63:0] e, o;
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd9, 16'd3);
        mem[1] = enc_i(6'h08, 5'd0, 5'd0, 16'd1);
        mem[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h100);
        mem[3] = enc_i(6'h2B, 5'd0, 5'd9, 16'h104);
        mem[4] = enc_i(6'h2B, 5'd0, 5'd0, 16'h108);
        exp_q.push_back({32'h100, 32'd3});
        exp_q.push_back({32'h104, 32'd3});
        exp_q.push_back({32'h108, 32'd0});
        sel8 = 1'b1;
        do_reset();
        wait_stores(200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL n8_store: missing store, expected %h", e);
            end else begin
                o = obs_q.pop_front();
                $display("[TB] n8 store addr=%h data=%h", o[63:32], o[31:0]);
                if (o !== e) begin fails++; $display("FAIL n8_store: got %h expected %h", o, e); end
            end
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch();
        test_exceptions();
        test_nregs8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
